// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // True when the address names the hard-wired zero register.
  function automatic logic is_reg_zero(input logic [AW-1:0] addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans requesters starting at ptr and
// returns a one-hot grant plus the pointer to use after that grant.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    next_ptr
);

  // First valid requester at or after ptr (wrapping) wins.
  always_comb begin
    int   idx;
    logic found;
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((idx + 1) % N_REQ);
      end else begin
        found    = found;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Round-robin grants among N_REQ requesters, a registered write stage and a
// pending-write scoreboard for RAW detection at issue.
// Optional macro REGFILE_WB_BYPASS_EN adds forwarding outputs from the write
// stage and masks busy for a register being written this cycle.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int AW    = regfile_pkg::AW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rf_write,
  output logic [AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic                  sb_set_valid,
  input  logic [AW-1:0]         sb_set_addr,
  input  logic [AW-1:0]         rs1_addr,
  input  logic [AW-1:0]         rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

  import regfile_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    gnt_s;
  logic                gnt_any_s;
  logic [PW-1:0]       ptr_q, ptr_d, ptr_next_s;
  logic [AW-1:0]       sel_addr_s;
  logic [XLEN-1:0]     sel_data_s;
  logic                rf_write_q, rf_write_d;
  logic [AW-1:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [NUM_REGS-1:0] sb_set_mask_s, sb_clr_mask_s;
  logic                rs1_pend_s, rs2_pend_s;
  logic                rs1_fwd_s, rs2_fwd_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (ptr_q),
    .gnt      (gnt_s),
    .next_ptr (ptr_next_s)
  );

  assign req_ready = gnt_s;
  assign gnt_any_s = |gnt_s;

  // Pointer advances past the granted requester and holds otherwise.
  always_comb begin
    if (gnt_any_s) begin
      ptr_d = ptr_next_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // AND-OR mux of the granted requester's address and data (grant is one-hot).
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({AW{gnt_s[i]}}   & req_addr[i*AW +: AW]);
      sel_data_s = sel_data_s | ({XLEN{gnt_s[i]}} & req_data[i*XLEN +: XLEN]);
    end
  end

  // Write stage: load on grant (x0 writes are suppressed), hold addr/data when idle.
  always_comb begin
    if (gnt_any_s) begin
      rf_write_d = !is_reg_zero(sel_addr_s);
      rf_waddr_d = sel_addr_s;
      rf_wdata_d = sel_data_s;
    end else begin
      rf_write_d = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // Scoreboard update: clear on the write edge, set from issue; set wins a tie.
  always_comb begin
    sb_clr_mask_s = rf_write_q ? (NUM_REGS'(1) << rf_waddr_q) : '0;
    sb_set_mask_s = (sb_set_valid && !is_reg_zero(sb_set_addr))
                    ? (NUM_REGS'(1) << sb_set_addr) : '0;
    sb_d          = (sb_q & ~sb_clr_mask_s) | sb_set_mask_s;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= '0;
      rf_write_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sb_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_write_q <= rf_write_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sb_q       <= sb_d;
    end
  end

  assign rf_write = rf_write_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign rs1_pend_s = sb_q[rs1_addr] & !is_reg_zero(rs1_addr);
  assign rs2_pend_s = sb_q[rs2_addr] & !is_reg_zero(rs2_addr);

`ifdef REGFILE_WB_BYPASS_EN
  // A register being written this cycle is served from the write stage.
  assign rs1_fwd_s    = rf_write_q & (rf_waddr_q == rs1_addr) & !is_reg_zero(rs1_addr);
  assign rs2_fwd_s    = rf_write_q & (rf_waddr_q == rs2_addr) & !is_reg_zero(rs2_addr);
  assign rs1_fwd      = rs1_fwd_s;
  assign rs2_fwd      = rs2_fwd_s;
  assign rs1_fwd_data = rf_wdata_q;
  assign rs2_fwd_data = rf_wdata_q;
`else
  // Without forwarding a register stays busy until the write has landed.
  assign rs1_fwd_s = 1'b0;
  assign rs2_fwd_s = 1'b0;
`endif

  assign rs1_busy = rs1_pend_s & ~rs1_fwd_s;
  assign rs2_busy = rs2_pend_s & ~rs2_fwd_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a behavioural reference model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int A  = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*A-1:0]  req_addr;
  logic [N*XL-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_write;
  logic [A-1:0]    rf_waddr;
  logic [XL-1:0]   rf_wdata;
  logic            sb_set_valid;
  logic [A-1:0]    sb_set_addr;
  logic [A-1:0]    rs1_addr;
  logic [A-1:0]    rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic            rs1_fwd, rs2_fwd;
  logic [XL-1:0]   rs1_fwd_data, rs2_fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  bit          m_sb [32];
  bit          m_wr;
  logic [A-1:0]  m_waddr;
  logic [XL-1:0] m_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL), .AW(A)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_write     (rf_write),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .sb_set_valid (sb_set_valid),
    .sb_set_addr  (sb_set_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs1_fwd      (rs1_fwd),
    .rs2_fwd      (rs2_fwd),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic bit exp_busy(input logic [A-1:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (m_wr && m_waddr == a) return 1'b0;
`endif
    return m_sb[a];
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
    m_wr    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic idle_inputs();
    req_valid    = '0;
    req_addr     = '0;
    req_data     = '0;
    sb_set_valid = 1'b0;
    sb_set_addr  = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
  endtask

  // One clock: capture inputs, let the edge happen, advance the model.
  task automatic tick();
    logic [N-1:0]  g;
    int            gi;
    logic [A-1:0]  ga;
    logic [XL-1:0] gd;
    bit            sv;
    logic [A-1:0]  sa;
    g  = exp_grant();
    gi = -1;
    for (int i = 0; i < N; i++) if (g[i]) gi = i;
    ga = (gi >= 0) ? req_addr[gi*A +: A]   : '0;
    gd = (gi >= 0) ? req_data[gi*XL +: XL] : '0;
    sv = sb_set_valid;
    sa = sb_set_addr;
    @(posedge clk);
    if (m_wr) m_sb[m_waddr] = 1'b0;
    if (sv && sa != 5'd0) m_sb[sa] = 1'b1;
    if (gi >= 0) begin
      m_wr    = (ga != 5'd0);
      m_waddr = ga;
      m_wdata = gd;
      m_ptr   = (gi + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (rf_write !== 1'b0) begin n_fail++; $display("FAIL reset_rf_write got=%b exp=0", rf_write); end
    if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=000", req_ready); end
    rstn = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[A-1:0];
      #1;
      n_checks++;
      if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs1_busy addr=%0d got=%b exp=0", a, rs1_busy); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    req_addr[1*A +: A]   = 5'd5;
    req_data[1*XL +: XL] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    tick();
    idle_inputs();
    #1;
    n_checks += 3;
    if (rf_write !== 1'b1) begin n_fail++; $display("FAIL single_rf_write got=%b exp=1", rf_write); end
    if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL single_rf_waddr got=%0d exp=5", rf_waddr); end
    if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf_wdata got=%h exp=deadbeef", rf_wdata); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*A +: A]   = A'($urandom_range(31, 1));
      req_data[i*XL +: XL] = $urandom;
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (req_ready !== seq[c]) begin n_fail++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, seq[c]); end
      if (c > 0) begin
        n_checks += 3;
        if (rf_write !== 1'b1) begin n_fail++; $display("FAIL rr_rf_write cycle=%0d got=%b exp=1", c, rf_write); end
        if (rf_waddr !== m_waddr) begin n_fail++; $display("FAIL rr_rf_waddr cycle=%0d got=%0d exp=%0d", c, rf_waddr, m_waddr); end
        if (rf_wdata !== m_wdata) begin n_fail++; $display("FAIL rr_rf_wdata cycle=%0d got=%h exp=%h", c, rf_wdata, m_wdata); end
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (rf_write !== 1'b1) begin n_fail++; $display("FAIL rr_last_write got=%b exp=1", rf_write); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    sb_set_valid = 1'b1;
    sb_set_addr  = 5'd7;
    tick();
    sb_set_valid = 1'b0;
    rs1_addr = 5'd7;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set got=%b exp=1", rs1_busy); end
    req_valid = 3'b001;
    req_addr[0 +: A]  = 5'd7;
    req_data[0 +: XL] = $urandom;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL sb_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    #1;
    n_checks += 2;
    if (rf_write !== 1'b1) begin n_fail++; $display("FAIL sb_rf_write got=%b exp=1", rf_write); end
`ifdef REGFILE_WB_BYPASS_EN
    if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_write_cycle got=%b exp=0", rs1_busy); end
    n_checks += 2;
    if (rs1_fwd !== 1'b1) begin n_fail++; $display("FAIL sb_fwd got=%b exp=1", rs1_fwd); end
    if (rs1_fwd_data !== m_wdata) begin n_fail++; $display("FAIL sb_fwd_data got=%h exp=%h", rs1_fwd_data, m_wdata); end
`else
    if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_write_cycle got=%b exp=1", rs1_busy); end
`endif
    tick();
    #1;
    n_checks++;
    if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_cleared got=%b exp=0", rs1_busy); end
    tick();
  endtask

  task automatic test_x0();
    idle_inputs();
    req_valid = 3'b100;
    req_addr[2*A +: A]   = 5'd0;
    req_data[2*XL +: XL] = $urandom;
    #1;
    n_checks++;
    if (req_ready !== exp_grant() || req_ready !== 3'b100) begin
      n_fail++; $display("FAIL x0_ready got=%b exp=100", req_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf_write !== 1'b0) begin n_fail++; $display("FAIL x0_rf_write got=%b exp=0", rf_write); end
    sb_set_valid = 1'b1;
    sb_set_addr  = 5'd0;
    rs2_addr     = 5'd0;
    tick();
    sb_set_valid = 1'b0;
    #1;
    n_checks++;
    if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_rs2_busy got=%b exp=0", rs2_busy); end
    tick();
  endtask

  task automatic test_collision();
    idle_inputs();
    sb_set_valid = 1'b1;
    sb_set_addr  = 5'd9;
    tick();
    sb_set_valid = 1'b0;
    req_valid = 3'b001;
    req_addr[0 +: A]  = 5'd9;
    req_data[0 +: XL] = $urandom;
    tick();
    req_valid    = 3'b000;
    sb_set_valid = 1'b1;
    sb_set_addr  = 5'd9;
    #1;
    n_checks++;
    if (rf_write !== 1'b1 || rf_waddr !== 5'd9) begin
      n_fail++; $display("FAIL coll_write got=%b/%0d exp=1/9", rf_write, rf_waddr);
    end
    tick();
    sb_set_valid = 1'b0;
    rs1_addr = 5'd9;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got=%b exp=1", rs1_busy); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*A +: A]   = A'($urandom);
        req_data[i*XL +: XL] = $urandom;
      end
      sb_set_valid = ($urandom_range(2, 0) == 0);
      sb_set_addr  = A'($urandom);
      rs1_addr     = A'($urandom);
      rs2_addr     = A'($urandom);
      #1;
      eg = exp_grant();
      n_checks += 5;
      if (req_ready !== eg) begin n_fail++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, req_ready, eg); end
      if (rf_write !== m_wr) begin n_fail++; $display("FAIL rand_rf_write cycle=%0d got=%b exp=%b", c, rf_write, m_wr); end
      if (m_wr && (rf_waddr !== m_waddr || rf_wdata !== m_wdata)) begin
        n_fail++; $display("FAIL rand_rf_wbus cycle=%0d got=%0d/%h exp=%0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata);
      end
      if (rs1_busy !== exp_busy(rs1_addr)) begin n_fail++; $display("FAIL rand_rs1_busy cycle=%0d addr=%0d got=%b", c, rs1_addr, rs1_busy); end
      if (rs2_busy !== exp_busy(rs2_addr)) begin n_fail++; $display("FAIL rand_rs2_busy cycle=%0d addr=%0d got=%b", c, rs2_addr, rs2_busy); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*A +: A]   = A'($urandom_range(31, 1));
      req_data[i*XL +: XL] = $urandom;
    end
    for (int a = 1; a < 4; a++) begin
      sb_set_valid = 1'b1;
      sb_set_addr  = A'(a * 5);
      tick();
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (rf_write !== 1'b0) begin n_fail++; $display("FAIL midrst_rf_write got=%b exp=0", rf_write); end
    idle_inputs();
    model_reset();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[A-1:0];
      rs2_addr = A'(31 - a);
      #1;
      n_checks += 2;
      if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_rs1_busy addr=%0d got=%b exp=0", a, rs1_busy); end
      if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_rs2_busy addr=%0d got=%b exp=0", 31 - a, rs2_busy); end
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_x0();
    test_collision();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between several writeback requesters (ALU, load unit, CSR unit) using round-robin arbitration and a valid/ready handshake. It drives the register-file write port through a registered stage. It also keeps a 32-entry pending-write scoreboard so the issue stage can detect RAW hazards on rs1/rs2. Sits between the execute/memory units and the register file.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*AW  per-requester destination register, requester i at [i*AW +: AW]
req_data  in  N_REQ*XLEN  per-requester write data, requester i at [i*XLEN +: XLEN]
req_ready  out  N_REQ  one-hot grant; handshake completes when valid & ready
rf_write  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  XLEN  register-file write data
sb_set_valid  in  1  issue stage marks a destination as pending
sb_set_addr  in  AW  destination register being marked
rs1_addr  in  AW  issue-stage source 1 address
rs2_addr  in  AW  issue-stage source 2 address
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write

Behaviour:
- Reset, async on rstn low: rf_write=0, rf_waddr=0, rf_wdata=0, RR pointer=0, all scoreboard bits=0. Reset mid-handshake discards the output stage and any pending bits.
- Arbitration is combinational round-robin starting at the pointer. At most one req_ready bit is high, and only for a valid requester. req_ready is 0 when no request is valid.
- After a grant to requester i, the pointer becomes (i+1) mod N_REQ. With no grant, the pointer holds.
- Requester rule: once valid is asserted, addr, data and valid must stay stable until ready. The arbiter does not depend on this for correctness.
- Output stage: a grant in cycle t loads rf_write=1, rf_waddr and rf_wdata at the end of cycle t. The register file is therefore written at the end of cycle t+1. With no grant, rf_write=0 next cycle and addr/data hold.
- x0: a request to addr 0 is granted normally, but rf_write stays 0. sb_set to addr 0 is ignored. rsN_busy is always 0 for address 0.
- Scoreboard:
  - bit[sb_set_addr] is set at the clock edge when sb_set_valid=1.
  - bit[rf_waddr] is cleared at the clock edge when rf_write=1 (same edge the register file updates).
  - If set and clear hit the same register in the same cycle, set wins.
- rsN_busy = scoreboard bit for rsN_addr, combinational.
- Back-to-back grants are allowed, one per cycle, giving a sustained throughput of 1 write per cycle.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined: adds outputs rs1_fwd, rs2_fwd (1 bit each) and rs1_fwd_data, rs2_fwd_data (XLEN each).
  - rsN_fwd = rf_write & (rf_waddr==rsN_addr) & (rsN_addr!=0).
  - rsN_fwd_data = rf_wdata.
  - rsN_busy is masked to 0 when rsN_fwd=1.
- Undefined: these ports are absent, and rsN_busy stays high through the output-stage cycle.

Decomposition:
- Package regfile_pkg holds XLEN, AW, NUM_REGS=32, and the constant REG_ZERO=5'd0.
- One sub-module, rr_arbiter (N_REQ parameter): takes the request vector and pointer, returns a one-hot grant and the next pointer.
- The scoreboard and output stage live in the top level.

Test Plan:
1. Reset then idle: all outputs 0, rs1_busy=0 for every rs1_addr 0..31.
2. Single request: req_valid=3'b010, addr=5, data=0xDEADBEEF -> req_ready=3'b010 in the same cycle; next cycle rf_write=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
3. All three requesters held valid for 6 cycles starting from ptr=0 -> grants 0,1,2,0,1,2, and rf_write stays high every cycle after the first.
4. Scoreboard: sb_set addr=7; next cycle rs1_addr=7 gives rs1_busy=1; requester 0 writes x7 -> busy=1 through the rf_write cycle and 0 after it (without bypass); with bypass, busy=0 and rs1_fwd=1 during the rf_write cycle.
5. x0: request addr=0 -> req_ready=1, rf_write stays 0; sb_set addr=0 -> rs2_busy stays 0 with rs2_addr=0.
6. Set/clear collision: rf_write for x9 in the same cycle as sb_set addr=9 -> bit 9 remains 1; assert rstn=0 mid-stream -> all bits 0 and rf_write=0 immediately.
